lcd_bf_ctrl: RTL and testbench

Parametrised HD44780-class character-LCD bus controller with busy-flag polling. Replaces the fixed 8-bit controller: it supports 8-bit or 4-bit bus width, instruction and data-register reads, configurable E-strobe timing, and an optional busy-flag timeout. It sits between the LCD command sequencer (valid/ready request port) and the LCD pads (tri-state data bus split into out/in/output-enable).

---
 rtl/lcd_bf_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_bf_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bf_ctrl.sv
// lcd_bf_ctrl: HD44780-class LCD bus controller, 8- or 4-bit bus, busy-flag polling.
// Define LCD_BF_TIMEOUT_EN to bound busy polling to BF_TIMEOUT cycles (sets o_timeout).
module lcd_bf_ctrl #(
    parameter int BUS_W      = 8,
    parameter int T_AS       = 2,
    parameter int T_PW       = 25,
    parameter int T_CYC      = 25,
    parameter int BF_TIMEOUT = 100000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en_lcd,
    output logic             o_ready,
    input  logic             i_rs,
    input  logic             i_rw,
    input  logic             i_no_bf,
    input  logic [7:0]       i_data,
    output logic [7:0]       o_rdata,
    output logic             o_done_lcd,
    output logic             o_timeout,
    output logic [BUS_W-1:0] o_LCD_DATA,
    input  logic [BUS_W-1:0] i_LCD_DATA,
    output logic             o_LCD_DATA_OE,
    output logic             o_LCD_E,
    output logic             o_LCD_RW,
    output logic             o_LCD_RS,
    output logic             o_LCD_ON,
    output logic             o_LCD_BLON
);
    localparam int T_MAX = (T_AS > T_PW) ? ((T_AS > T_CYC) ? T_AS : T_CYC)
                                         : ((T_PW > T_CYC) ? T_PW : T_CYC);
    localparam int CW    = $clog2(T_MAX + 1);
    localparam bit NIB   = (BUS_W == 4);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_POLL, S_DONE} state_t;
    typedef enum logic [1:0] {P_SETUP, P_EHI, P_ELO} phase_t;

    state_t          r_state, w_state_nxt;
    phase_t          r_ph, w_ph_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt, w_ph_len;
    logic            r_nib, w_nib_nxt;
    logic            r_rs, r_rw, r_nobf, r_busy;
    logic [7:0]      r_data, r_rd, r_rdata;
    logic            r_ready, r_done, r_on;
    logic            r_e, r_lrs, r_lrw, r_oe;
    logic [BUS_W-1:0] r_dout;
    logic            w_start, w_ph_end, w_sample, w_to_hit, w_act_nxt;
    logic            w_rs, w_rw;
    logic [7:0]      w_data, w_pad8, w_rd_nxt, w_out8;

    assign w_ph_len  = (r_ph == P_SETUP) ? CW'(T_AS - 1) :
                       (r_ph == P_EHI)   ? CW'(T_PW - 1) : CW'(T_CYC - 1);
    assign w_ph_end  = (r_cnt == w_ph_len);
    assign w_sample  = (r_state == S_XFER || r_state == S_POLL) && r_ph == P_EHI && w_ph_end;
    assign w_act_nxt = (w_state_nxt == S_XFER || w_state_nxt == S_POLL);

    // On the accept edge the request is not yet registered, so pads take it from the ports
    assign w_rs   = (r_state == S_IDLE) ? i_rs   : r_rs;
    assign w_rw   = (r_state == S_IDLE) ? i_rw   : r_rw;
    assign w_data = (r_state == S_IDLE) ? i_data : r_data;

    assign w_pad8   = 8'(i_LCD_DATA);
    assign w_rd_nxt = !NIB  ? w_pad8 :
                      r_nib ? {r_rd[7:4], w_pad8[3:0]} : {w_pad8[3:0], r_rd[3:0]};
    assign w_out8   = (w_rw || w_state_nxt == S_POLL) ? 8'h00 :
                      !NIB      ? w_data :
                      w_nib_nxt ? {4'h0, w_data[3:0]} : {4'h0, w_data[7:4]};

    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_cnt_nxt   = r_cnt;
        w_nib_nxt   = r_nib;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_en_lcd && r_ready) begin
                    w_state_nxt = S_XFER;
                    w_start     = 1'b1;
                end
            end
            S_XFER, S_POLL: begin
                if (!w_ph_end) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_cnt_nxt = '0;
                    if (r_ph == P_SETUP) begin
                        w_ph_nxt = P_EHI;
                    end else if (r_ph == P_EHI) begin
                        w_ph_nxt = P_ELO;
                    end else begin
                        w_ph_nxt  = P_SETUP;
                        w_nib_nxt = NIB && !r_nib;
                        if (NIB && !r_nib) begin
                            w_start = 1'b1;
                        end else if (r_state == S_XFER) begin
                            w_state_nxt = r_nobf ? S_DONE : S_POLL;
                            w_start     = !r_nobf;
                        end else begin
                            w_state_nxt = (r_busy && !w_to_hit) ? S_POLL : S_DONE;
                            w_start     = r_busy && !w_to_hit;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ph    <= P_SETUP;
            r_cnt   <= '0;
            r_nib   <= 1'b0;
            r_rs    <= 1'b0;
            r_rw    <= 1'b0;
            r_nobf  <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= 8'h00;
            r_rd    <= 8'h00;
            r_rdata <= 8'h00;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_on    <= 1'b0;
            r_e     <= 1'b0;
            r_lrs   <= 1'b0;
            r_lrw   <= 1'b0;
            r_oe    <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
            r_cnt   <= w_cnt_nxt;
            r_nib   <= w_nib_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            r_on    <= 1'b1;
            r_e     <= w_act_nxt && (w_ph_nxt == P_EHI);
            if (r_state == S_IDLE && w_start) begin
                r_rs   <= i_rs;
                r_rw   <= i_rw;
                r_nobf <= i_no_bf;
                r_data <= i_data;
            end
            if (w_sample && r_state == S_XFER && r_rw)
                r_rd <= w_rd_nxt;
            // Busy flag is D7 of the first (high) nibble only
            if (w_sample && r_state == S_POLL && !r_nib)
                r_busy <= i_LCD_DATA[BUS_W-1];
            if (w_state_nxt == S_DONE && r_rw)
                r_rdata <= r_rd;
            if (w_start) begin
                r_lrs  <= (w_state_nxt == S_POLL) ? 1'b0 : w_rs;
                r_lrw  <= (w_state_nxt == S_POLL) || w_rw;
                r_oe   <= (w_state_nxt != S_POLL) && !w_rw;
                r_dout <= w_out8[BUS_W-1:0];
            end else if (w_state_nxt == S_DONE) begin
                r_oe <= 1'b0;
            end
        end
    end

`ifdef LCD_BF_TIMEOUT_EN
    localparam int TW = $clog2(BF_TIMEOUT + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_tout;

    // Counts cycles spent in POLL, saturating once the limit is reached
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcnt <= '0;
            r_tout <= 1'b0;
        end else begin
            if (r_state != S_POLL)
                r_tcnt <= '0;
            else if (r_tcnt != TW'(BF_TIMEOUT))
                r_tcnt <= r_tcnt + 1'b1;
            r_tout <= (w_state_nxt == S_DONE) && (r_state == S_POLL) && w_to_hit;
        end
    end

    assign w_to_hit  = (32'(r_tcnt) + 32'd1) >= 32'(BF_TIMEOUT);
    assign o_timeout = r_tout;
`else
    // Never true for a legal BF_TIMEOUT (>=1): polling is unbounded
    assign w_to_hit  = (BF_TIMEOUT < 1);
    assign o_timeout = 1'b0;
`endif

    assign o_ready       = r_ready;
    assign o_rdata       = r_rdata;
    assign o_done_lcd    = r_done;
    assign o_LCD_DATA    = r_dout;
    assign o_LCD_DATA_OE = r_oe;
    assign o_LCD_E       = r_e;
    assign o_LCD_RW      = r_lrw;
    assign o_LCD_RS      = r_lrs;
    assign o_LCD_ON      = r_on;
    assign o_LCD_BLON    = r_on;
endmodule

// File: tb/tb_lcd_bf_ctrl.sv
// tb_lcd_bf_ctrl: table-driven bench for lcd_bf_ctrl, one 8-bit and one 4-bit instance.
module tb_lcd_bf_ctrl;
    logic clk = 1'b0, rst_n = 1'b1;
    logic en8 = 1'b0, en4 = 1'b0, rs = 1'b0, rw = 1'b0, nobf = 1'b0, sel4 = 1'b0;
    logic [7:0] data = 8'h00, pad8 = 8'h00;
    logic [3:0] pad4 = 4'h0;
    logic rdy8, done8, to8, oe8, e8, lrw8, lrs8, on8, blon8;
    logic rdy4, done4, to4, oe4, e4, lrw4, lrs4, on4, blon4;
    logic [7:0] rdata8, rdata4, dout8;
    logic [3:0] dout4;
    logic rdy, done, tmo, oe, e, lrw, lrs;
    logic [7:0] rdata, dout;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    lcd_bf_ctrl #(.BUS_W(8), .T_AS(1), .T_PW(2), .T_CYC(3), .BF_TIMEOUT(20)) u8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en_lcd(en8), .o_ready(rdy8), .i_rs(rs), .i_rw(rw),
        .i_no_bf(nobf), .i_data(data), .o_rdata(rdata8), .o_done_lcd(done8), .o_timeout(to8),
        .o_LCD_DATA(dout8), .i_LCD_DATA(pad8), .o_LCD_DATA_OE(oe8), .o_LCD_E(e8),
        .o_LCD_RW(lrw8), .o_LCD_RS(lrs8), .o_LCD_ON(on8), .o_LCD_BLON(blon8));

    lcd_bf_ctrl #(.BUS_W(4), .T_AS(1), .T_PW(2), .T_CYC(3), .BF_TIMEOUT(20)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en_lcd(en4), .o_ready(rdy4), .i_rs(rs), .i_rw(rw),
        .i_no_bf(nobf), .i_data(data), .o_rdata(rdata4), .o_done_lcd(done4), .o_timeout(to4),
        .o_LCD_DATA(dout4), .i_LCD_DATA(pad4), .o_LCD_DATA_OE(oe4), .o_LCD_E(e4),
        .o_LCD_RW(lrw4), .o_LCD_RS(lrs4), .o_LCD_ON(on4), .o_LCD_BLON(blon4));

    assign rdy   = sel4 ? rdy4 : rdy8;
    assign done  = sel4 ? done4 : done8;
    assign tmo   = sel4 ? to4 : to8;
    assign oe    = sel4 ? oe4 : oe8;
    assign e     = sel4 ? e4 : e8;
    assign lrw   = sel4 ? lrw4 : lrw8;
    assign lrs   = sel4 ? lrs4 : lrs8;
    assign rdata = sel4 ? rdata4 : rdata8;
    assign dout  = sel4 ? {4'h0, dout4} : dout8;

    typedef struct {
        string      name;
        bit         b4, rs, rw, nobf;
        logic [7:0] data, pa, pb;
        int         sw, lat, strobes;
        bit         tout;
        logic [7:0] rdata, d1, d2;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Pad value is pa until sw E-strobes have finished, pb afterwards
    task automatic run(input vec_t v);
        int cyc, done_cyc, strobes, falls, nx;
        logic [7:0] d1, d2, rdat, pdout;
        logic oe1, rs1, rw1, tout, pe, prs, prw, poll_ok, stable_ok;
        sel4 = v.b4;
        nx = v.b4 ? 2 : 1;
        pad8 = (v.sw > 0) ? v.pa : v.pb;
        pad4 = pad8[3:0];
        @(negedge clk);
        chk($sformatf("%s ready_before", v.name), rdy, 1);
        rs = v.rs; rw = v.rw; nobf = v.nobf; data = v.data;
        if (v.b4) en4 = 1'b1; else en8 = 1'b1;
        @(posedge clk);
        #1;
        en4 = 1'b0; en8 = 1'b0;
        cyc = 0; done_cyc = -1; strobes = 0; falls = 0;
        d1 = 8'hxx; d2 = 8'hxx; rdat = 8'hxx; oe1 = 1'bx; rs1 = 1'bx; rw1 = 1'bx; tout = 1'bx;
        pe = 1'b0; pdout = 8'h00; prs = 1'b0; prw = 1'b0; poll_ok = 1'b1; stable_ok = 1'b1;
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (e && !pe) begin
                strobes++;
                if (strobes == 1) begin
                    d1 = dout; oe1 = oe; rs1 = lrs; rw1 = lrw;
                end
                if (strobes == 2) d2 = dout;
                if (strobes > nx && (lrw !== 1'b1 || oe !== 1'b0 || lrs !== 1'b0)) poll_ok = 1'b0;
            end
            if (e && pe && (dout !== pdout || lrs !== prs || lrw !== prw)) stable_ok = 1'b0;
            if (pe && !e) begin
                falls++;
                pad8 = (falls < v.sw) ? v.pa : v.pb;
                pad4 = pad8[3:0];
            end
            if (done) begin
                done_cyc = cyc; tout = tmo; rdat = rdata;
            end
            pe = e; pdout = dout; prs = lrs; prw = lrw;
        end
        chk($sformatf("%s latency", v.name), done_cyc, v.lat);
        chk($sformatf("%s strobes", v.name), strobes, v.strobes);
        chk($sformatf("%s timeout", v.name), {31'd0, tout}, {31'd0, v.tout});
        chk($sformatf("%s rdata", v.name), rdat, v.rdata);
        chk($sformatf("%s stable_while_E", v.name), stable_ok, 1);
        chk($sformatf("%s rs", v.name), rs1, v.rs);
        chk($sformatf("%s rw", v.name), rw1, v.rw);
        chk($sformatf("%s oe", v.name), oe1, !v.rw);
        if (!v.rw) chk($sformatf("%s data1", v.name), d1, v.d1);
        if (!v.rw && v.b4) chk($sformatf("%s data2", v.name), d2, v.d2);
        if (!v.nobf) chk($sformatf("%s poll_pads", v.name), poll_ok, 1);
        @(negedge clk);
        chk($sformatf("%s ready_after", v.name), rdy, 1);
        chk($sformatf("%s done_one_cycle", v.name), done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #2;
        chk("rst ready", {rdy8, rdy4}, 0);
        chk("rst done", {done8, done4}, 0);
        chk("rst timeout", {to8, to4}, 0);
        chk("rst rdata", {rdata8, rdata4}, 0);
        chk("rst pads", {dout8, dout4, oe8, oe4, e8, e4, lrw8, lrw4, lrs8, lrs4}, 0);
        chk("rst on_blon", {on8, blon8, on4, blon4}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst ready", {rdy8, rdy4}, 2'b11);
        chk("post_rst on_blon", {on8, blon8, on4, blon4}, 4'hF);

        vecs[0] = '{"w8_41_nobf", 1'b0, 1'b1, 1'b0, 1'b1, 8'h41, 8'h00, 8'h00, 0, 7, 1, 1'b0, 8'h00, 8'h41, 8'h00};
        vecs[1] = '{"w4_28_nobf", 1'b1, 1'b0, 1'b0, 1'b1, 8'h28, 8'h00, 8'h00, 0, 13, 2, 1'b0, 8'h00, 8'h02, 8'h08};
        vecs[2] = '{"w8_01_busy2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h80, 8'h00, 3, 25, 4, 1'b0, 8'h00, 8'h01, 8'h00};
        vecs[3] = '{"r4_5A", 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h05, 8'h0A, 1, 13, 2, 1'b0, 8'h5A, 8'h00, 8'h00};
        vecs[4] = '{"r8_C3", 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'hC3, 8'hC3, 0, 7, 1, 1'b0, 8'hC3, 8'h00, 8'h00};
        vecs[5] = '{"w8_55_hold", 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 8'h00, 8'h00, 0, 7, 1, 1'b0, 8'hC3, 8'h55, 8'h00};
        vecs[6] = '{"w4_28_bf_d7lo", 1'b1, 1'b0, 1'b0, 1'b0, 8'h28, 8'h00, 8'h08, 3, 25, 4, 1'b0, 8'h5A, 8'h02, 8'h08};
`ifdef LCD_BF_TIMEOUT_EN
        vecs[7] = '{"w8_bf_timeout", 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h80, 8'h80, 0, 31, 5, 1'b1, 8'hC3, 8'h01, 8'h00};
`else
        vecs[7] = '{"w8_bf_long", 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h80, 8'h00, 10, 67, 11, 1'b0, 8'hC3, 8'h01, 8'h00};
`endif
        for (int i = 0; i < 8; i++) run(vecs[i]);

        // Request held while busy must be ignored, no queued transfer afterwards
        sel4 = 1'b0; pad8 = 8'h00;
        @(negedge clk);
        rs = 1'b1; rw = 1'b0; nobf = 1'b1; data = 8'h3C; en8 = 1'b1;
        @(posedge clk);
        #1;
        rs = 1'b0; data = 8'hFF;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 2) begin
                chk("ign data", dout8, 8'h3C);
                chk("ign rs", lrs8, 1);
            end
            if (c == 4) en8 = 1'b0;
            if (c == 7) chk("ign done", done8, 1);
        end
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (e8) n++;
        end
        chk("ign no_restart", n, 0);

        // Reset while E is high: everything drops at once, no done pulse
        @(negedge clk);
        rs = 1'b1; rw = 1'b0; nobf = 1'b1; data = 8'h41; en8 = 1'b1;
        @(posedge clk);
        #1 en8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst e_high", e8, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst pads", {e8, oe8, dout8, lrs8, lrw8}, 0);
        chk("midrst status", {rdy8, done8, to8, on8, blon8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8) n++;
        end
        chk("midrst no_done", n, 0);
        chk("midrst ready", rdy8, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
